// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pkg
//  Description : Shared RV32I definitions for the instruction decoder and
//                encoder: supported opcodes, encoder FSM state type, the
//                decoded field bundle, and the field-to-word packing function.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package instr_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_STREAM = 2'd1,
    ENC_DRAIN  = 2'd2
  } enc_state_e;

  // Decoded field bundle; imm uses the decoder's 12-bit packing for every
  // format (for B it is the branch offset already shifted right by one).
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } fields_t;

  function automatic logic is_supported(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_STORE) ||
           (opcode == OP_REG)  || (opcode == OP_BRANCH);
  endfunction

  // Unknown opcodes fall through to the R layout.
  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] word;
    case (f.opcode)
      OP_LOAD, OP_IMM:
        word = {f.imm, f.rs1, f.funct3, f.rd, f.opcode};
      OP_STORE:
        word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      OP_BRANCH:
        word = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, f.funct3,
                f.imm[3:0], f.imm[10], f.opcode};
      default:
        word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fifo
//  Description : Synchronous FIFO holding {encoded word, byte address} pairs.
//                Push is ignored when full, pop is ignored when empty; there
//                is no write-to-read bypass.
//  Ports       : clk_in/rst_in   clock, synchronous active-high reset
//                push/din        write request and data
//                pop/dout        read request and head data
//                full/empty      occupancy flags
//                one_left        exactly one entry stored
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == (PTR_W+1)'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign dout     = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs decoded RV32I fields (I, S, R, B formats) into 32-bit
//                words, queues them and streams each with an incrementing
//                byte address to instruction-memory write logic.
//  Ports       : clk_in, rst_in            clock, synchronous active-high reset
//                start_in, base_addr_in    begin a program at base address
//                fld_*/opcode_in..funct7_in field bundle handshake and data
//                instr_valid_out/ready_in  encoded word handshake
//                instr_out, addr_out       encoded word and its byte address
//                done_out                  pulse when the last word drains
//                busy_out                  encoder not idle
//                err_out                   sticky bad-opcode flag (optional)
//  Config      : INSTR_ENCODER_OPCHECK_EN drops unsupported opcodes and
//                adds err_out; otherwise they are encoded with the R layout.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic              fld_valid_in,
  output logic              fld_ready_out,
  input  logic              fld_last_in,
  input  logic [6:0]        opcode_in,
  input  logic [4:0]        rs1_in,
  input  logic [4:0]        rs2_in,
  input  logic [4:0]        rd_in,
  input  logic [11:0]       imm_in,
  input  logic [2:0]        funct3_in,
  input  logic [6:0]        funct7_in,
  output logic              instr_valid_out,
  input  logic              instr_ready_in,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              done_out,
  output logic              busy_out
`ifdef INSTR_ENCODER_OPCHECK_EN
  ,
  output logic              err_out
`endif
);

  localparam int WIDTH = 32 + ADDR_W;

  enc_state_e        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              done;
  fields_t           fld;
  logic [31:0]       encoded;
  logic              accept;
  logic              push;
  logic [WIDTH-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_one_left;

  always_comb begin
    fld        = '0;
    fld.opcode = opcode_in;
    fld.rs1    = rs1_in;
    fld.rs2    = rs2_in;
    fld.rd     = rd_in;
    fld.imm    = imm_in;
    fld.funct3 = funct3_in;
    fld.funct7 = funct7_in;
  end

  assign encoded       = encode(fld);
  assign fld_ready_out = (state == ENC_STREAM) && !fifo_full;
  assign accept        = fld_valid_in && fld_ready_out;

`ifdef INSTR_ENCODER_OPCHECK_EN
  logic err;
  logic op_ok;
  assign op_ok   = is_supported(opcode_in);
  assign push    = accept && op_ok;
  assign err_out = err;
`else
  assign push    = accept;
`endif

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (push),
    .din      ({encoded, addr_cnt}),
    .pop      (instr_ready_in),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

  assign instr_valid_out = !fifo_empty;
  assign instr_out       = fifo_dout[WIDTH-1:ADDR_W];
  assign addr_out        = fifo_dout[ADDR_W-1:0];
  assign done_out        = done;
  assign busy_out        = (state != ENC_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ENC_IDLE;
      addr_cnt <= '0;
      done     <= 1'b0;
`ifdef INSTR_ENCODER_OPCHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ENC_IDLE: begin
          if (start_in) begin
            state    <= ENC_STREAM;
            addr_cnt <= base_addr_in;
`ifdef INSTR_ENCODER_OPCHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        ENC_STREAM: begin
          if (push) addr_cnt <= addr_cnt + ADDR_W'(4);
`ifdef INSTR_ENCODER_OPCHECK_EN
          if (accept && !op_ok) err <= 1'b1;
`endif
          if (accept && fld_last_in) state <= ENC_DRAIN;
        end
        ENC_DRAIN: begin
          // Leave on the edge that pops the final word so done lines up
          // with the first empty cycle.
          if (fifo_empty || (fifo_one_left && instr_ready_in)) begin
            state <= ENC_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ENC_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder: table of field
//                bundles with hand-computed words, plus directed sequences
//                for backpressure, address wrap and mid-stream reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [31:0] base_addr_in = '0;
  logic        fld_valid_in = 1'b0;
  logic        fld_ready_out;
  logic        fld_last_in = 1'b0;
  logic [6:0]  opcode_in = '0;
  logic [4:0]  rs1_in = '0;
  logic [4:0]  rs2_in = '0;
  logic [4:0]  rd_in = '0;
  logic [11:0] imm_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [6:0]  funct7_in = '0;
  logic        instr_valid_out;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] addr_out;
  logic        done_out;
  logic        busy_out;
`ifdef INSTR_ENCODER_OPCHECK_EN
  logic        err_out;
`endif

  instr_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .base_addr_in    (base_addr_in),
    .fld_valid_in    (fld_valid_in),
    .fld_ready_out   (fld_ready_out),
    .fld_last_in     (fld_last_in),
    .opcode_in       (opcode_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rd_in           (rd_in),
    .imm_in          (imm_in),
    .funct3_in       (funct3_in),
    .funct7_in       (funct7_in),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .instr_out       (instr_out),
    .addr_out        (addr_out),
    .done_out        (done_out),
    .busy_out        (busy_out)
`ifdef INSTR_ENCODER_OPCHECK_EN
    ,
    .err_out         (err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [31:0] got_i[$];
  logic [31:0] got_a[$];
  vec_t vecs[8];

  always @(posedge clk_in) cyc++;

  // Transfers are recorded mid-cycle, when handshake signals are settled.
  always @(negedge clk_in) begin
    if (!rst_in && instr_valid_out && instr_ready_in) begin
      got_i.push_back(instr_out);
      got_a.push_back(addr_out);
      last_pop_cyc = cyc;
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [11:0] imm, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] exp);
    vec_t v;
    v.opcode = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.f3 = f3; v.f7 = f7; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t mk_add(input int rd);
    return mk(7'h33, 5'd1, 5'd2, 5'(rd), 12'h000, 3'd0, 7'h00, 32'h00208033 | (32'(rd) << 7));
  endfunction

  // Called in the phase just after a rising edge.
  task automatic send(input vec_t v, input bit last);
    int n;
    opcode_in = v.opcode; rs1_in = v.rs1; rs2_in = v.rs2; rd_in = v.rd;
    imm_in = v.imm; funct3_in = v.f3; funct7_in = v.f7;
    fld_last_in = last;
    fld_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!fld_ready_out && n < 50);
    if (!fld_ready_out) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: fld_ready_out stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk_in);
    #1;
    fld_valid_in = 1'b0;
    fld_last_in = 1'b0;
  endtask

  task automatic start(input logic [31:0] base);
    @(posedge clk_in);
    #1;
    start_in = 1'b1;
    base_addr_in = base;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int d0;
    vec_t v;
    vecs[0] = mk(7'h03, 5'd1, 5'd0,  5'd5,  12'h004, 3'd2, 7'h00, 32'h0040A283); // lw x5,4(x1)
    vecs[1] = mk(7'h13, 5'd0, 5'd31, 5'd1,  12'h005, 3'd0, 7'h7F, 32'h00500093); // addi, junk rs2/f7
    vecs[2] = mk(7'h33, 5'd1, 5'd2,  5'd3,  12'hFFF, 3'd0, 7'h00, 32'h002081B3); // add, junk imm
    vecs[3] = mk(7'h23, 5'd1, 5'd2,  5'd0,  12'h008, 3'd2, 7'h00, 32'h0020A423); // sw x2,8(x1)
    vecs[4] = mk(7'h63, 5'd1, 5'd2,  5'd0,  12'h004, 3'd0, 7'h00, 32'h00208463); // beq
    vecs[5] = mk(7'h63, 5'd1, 5'd2,  5'd31, 12'hFFF, 3'd1, 7'h00, 32'hFE209FE3); // B, all imm bits
    vecs[6] = mk(7'h23, 5'd6, 5'd5,  5'd0,  12'hFFF, 3'd0, 7'h00, 32'hFE530FA3); // S, all imm bits
    vecs[7] = mk(7'h33, 5'd1, 5'd2,  5'd3,  12'h000, 3'd0, 7'h20, 32'h402081B3); // sub

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", 32'(instr_valid_out), 32'd0);
    chk("rst_fld_ready", 32'(fld_ready_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);

    // Table run: every format, base 0x100
    instr_ready_in = 1'b1;
    got_i.delete(); got_a.delete();
    start(32'h100);
    @(negedge clk_in);
    chk("stream_busy", 32'(busy_out), 32'd1);
    @(posedge clk_in);
    #1;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) send(vecs[i], i == 7);
    wait_done(d0);
    chk("tbl_count", 32'(got_i.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_i.size(); i++) begin
      chk($sformatf("tbl_instr[%0d]", i), got_i[i], vecs[i].exp);
      chk($sformatf("tbl_addr[%0d]", i), got_a[i], 32'h100 + 32'(4 * i));
    end
    chk("done_latency", 32'(done_cyc), 32'(last_pop_cyc + 1));
    @(negedge clk_in);
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("done_one_cycle", 32'(done_out), 32'd0);

    // Backpressure: DEPTH+1 bundles with consumer stalled
    instr_ready_in = 1'b0;
    got_i.delete(); got_a.delete();
    start(32'h40);
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) send(mk_add(i + 1), 1'b0);
    v = mk_add(5);
    opcode_in = v.opcode; rs1_in = v.rs1; rs2_in = v.rs2; rd_in = v.rd;
    imm_in = v.imm; funct3_in = v.f3; funct7_in = v.f7;
    fld_last_in = 1'b1;
    fld_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk("bp_fld_ready", 32'(fld_ready_out), 32'd0);
      chk("bp_head_instr", instr_out, mk_add(1).exp);
      chk("bp_head_addr", addr_out, 32'h40);
    end
    @(posedge clk_in);
    #1;
    instr_ready_in = 1'b1;
    send(v, 1'b1);
    wait_done(d0);
    chk("bp_count", 32'(got_i.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_i.size(); i++) begin
      chk($sformatf("bp_instr[%0d]", i), got_i[i], mk_add(i + 1).exp);
      chk($sformatf("bp_addr[%0d]", i), got_a[i], 32'h40 + 32'(4 * i));
    end

    // Address counter wrap
    got_i.delete(); got_a.delete();
    start(32'hFFFF_FFFC);
    d0 = done_cnt;
    send(vecs[0], 1'b0);
    send(vecs[3], 1'b1);
    wait_done(d0);
    chk("wrap_count", 32'(got_i.size()), 32'd2);
    if (got_i.size() >= 2) begin
      chk("wrap_addr0", got_a[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", got_a[1], 32'h0000_0000);
      chk("wrap_instr1", got_i[1], vecs[3].exp);
    end

`ifdef INSTR_ENCODER_OPCHECK_EN
    // Unsupported opcode dropped, flagged, address not advanced
    got_i.delete(); got_a.delete();
    start(32'h300);
    @(negedge clk_in);
    chk("err_clear", 32'(err_out), 32'd0);
    @(posedge clk_in);
    #1;
    d0 = done_cnt;
    send(mk(7'h7F, 5'd4, 5'd3, 5'd6, 12'h000, 3'd5, 7'h55, 32'h0), 1'b0);
    @(negedge clk_in);
    chk("err_set", 32'(err_out), 32'd1);
    @(posedge clk_in);
    #1;
    send(vecs[2], 1'b1);
    wait_done(d0);
    chk("err_count", 32'(got_i.size()), 32'd1);
    if (got_i.size() >= 1) begin
      chk("err_instr", got_i[0], vecs[2].exp);
      chk("err_addr", got_a[0], 32'h300);
    end
    chk("err_sticky", 32'(err_out), 32'd1);
`endif

    // Reset mid-STREAM with two words queued
    instr_ready_in = 1'b0;
    got_i.delete(); got_a.delete();
    start(32'h0);
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    d0 = done_cnt;
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("mrst_valid", 32'(instr_valid_out), 32'd0);
    chk("mrst_busy", 32'(busy_out), 32'd0);
    chk("mrst_fld_ready", 32'(fld_ready_out), 32'd0);
    chk("mrst_done", 32'(done_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("mrst_no_done", 32'(done_cnt), 32'(d0));
    chk("mrst_no_words", 32'(got_i.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
